// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// Requester side of the instruction memory. Owns the PC, presents it as the
// byte address to a zero-latency instruction memory, and buffers fetched
// {pc, instruction} pairs in a small FIFO that decode drains over valid/ready.
// A redirect flushes the buffer and reloads the PC; a halt word stops fetching
// until the next redirect or reset.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   instructionAddress  byte address to instruction memory (= pc register)
//   instruction         memory read data for instructionAddress, same cycle
//   redirectValid       flush buffer and load redirectTarget this cycle
//   redirectTarget      new pc, bits [1:0] ignored
//   fetchValid          head entry valid for decode
//   fetchReady          decode accepts the head entry
//   fetchInstruction    head entry instruction (0 when empty)
//   fetchPC             head entry pc (0 when empty)
//   halted              1 while fetching is stopped on a halt word
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instructionAddress,
    input  logic [31:0] instruction,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic        fetchValid,
    input  logic        fetchReady,
    output logic [31:0] fetchInstruction,
    output logic [31:0] fetchPC,
    output logic        halted
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]        r_fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_is_halt;
    logic w_run_ok;
    logic w_push;
    logic w_halt_go;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_is_halt = (instruction == HALT_WORD);

    // A redirect masks the handshake so nothing is consumed in a flush cycle.
    assign fetchValid = !w_empty && !redirectValid;
    assign w_pop      = fetchValid && fetchReady;

    // Push may reuse the slot freed by a same-cycle pop when full.
    assign w_run_ok  = (r_state == ST_RUN) && !redirectValid;
    assign w_push    = w_run_ok && (!w_full || w_pop) && !w_is_halt;
    assign w_halt_go = w_run_ok && w_is_halt;

    assign instructionAddress = r_pc;
    assign fetchPC            = w_empty ? 32'h0 : r_fifo_pc[r_rd_ptr];
    assign fetchInstruction   = w_empty ? 32'h0 : r_fifo_instr[r_rd_ptr];
    assign halted             = (r_state == ST_HALT);

    // PC, control state and fetch buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo_pc[i]    <= 32'h0;
                r_fifo_instr[i] <= 32'h0;
            end
        end else if (redirectValid) begin
            r_state  <= ST_RUN;
            r_pc     <= {redirectTarget[31:2], 2'b00};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]    <= r_pc;
                r_fifo_instr[r_wr_ptr] <= instruction;
                r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
                r_pc                   <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_halt_go) begin
                r_state <= ST_HALT;
            end
        end
    end

endmodule
